// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the segment-bus readback monitor.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_scan_pkg;

    localparam logic [6:0] PAT_0     = 7'h40;
    localparam logic [6:0] PAT_1     = 7'h79;
    localparam logic [6:0] PAT_2     = 7'h24;
    localparam logic [6:0] PAT_3     = 7'h30;
    localparam logic [6:0] PAT_4     = 7'h19;
    localparam logic [6:0] PAT_5     = 7'h12;
    localparam logic [6:0] PAT_6     = 7'h02;
    localparam logic [6:0] PAT_7     = 7'h78;
    localparam logic [6:0] PAT_8     = 7'h00;
    localparam logic [6:0] PAT_9     = 7'h10;
    localparam logic [6:0] PAT_DASH  = 7'h3F;
    localparam logic [6:0] PAT_BLANK = 7'h7F;

    localparam logic [3:0] CODE_DASH    = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hE;
    localparam logic [3:0] CODE_BLANK   = 4'hF;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Bus bundle between the segment-scan monitor and its consumer.
// SEG_SCAN_ERR_CNT_EN adds the invalid-commit counter output.
interface seg_scan_decoder_if #(
    parameter int NUM_DIGITS = 6
);
    logic [6:0]              i_seg;
    logic                    i_dp;
    logic [NUM_DIGITS-1:0]   i_dig_sel;
    logic                    i_err_clr;
    logic [4*NUM_DIGITS-1:0] o_digits;
    logic [NUM_DIGITS-1:0]   o_dp;
    logic [NUM_DIGITS-1:0]   o_valid;
    logic                    o_frame_done;
    logic                    o_err;
`ifdef SEG_SCAN_ERR_CNT_EN
    logic [7:0]              o_err_cnt;

    modport master (
        output i_seg, i_dp, i_dig_sel, i_err_clr,
        input  o_digits, o_dp, o_valid, o_frame_done, o_err, o_err_cnt
    );
    modport slave (
        input  i_seg, i_dp, i_dig_sel, i_err_clr,
        output o_digits, o_dp, o_valid, o_frame_done, o_err, o_err_cnt
    );
`else
    modport master (
        output i_seg, i_dp, i_dig_sel, i_err_clr,
        input  o_digits, o_dp, o_valid, o_frame_done, o_err
    );
    modport slave (
        input  i_seg, i_dp, i_dig_sel, i_err_clr,
        output o_digits, o_dp, o_valid, o_frame_done, o_err
    );
`endif
endinterface

// File: rtl/seg_pattern_lut.sv
// Combinational active-low 7-segment pattern to 4-bit code lookup.
module seg_pattern_lut
    import seg_scan_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] code,
    output logic       invalid
);

    always_comb begin
        code    = CODE_INVALID;
        invalid = 1'b0;
        case (pattern)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            PAT_DASH:  code = CODE_DASH;
            PAT_BLANK: code = CODE_BLANK;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Readback monitor for the multiplexed display bus: commits a digit once its
// pattern is stable for STABLE_CNT samples. SEG_SCAN_ERR_CNT_EN adds o_err_cnt.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int STABLE_CNT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    seg_scan_decoder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_TGT = CNT_W'(STABLE_CNT);

    logic [6:0]            s_seg, p_seg;
    logic                  s_dp, p_dp;
    logic [NUM_DIGITS-1:0] s_sel, p_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_seg <= '0;
            s_dp  <= 1'b0;
            s_sel <= '0;
            p_seg <= '0;
            p_dp  <= 1'b0;
            p_sel <= '0;
        end else begin
            s_seg <= bus.i_seg;
            s_dp  <= bus.i_dp;
            s_sel <= bus.i_dig_sel;
            p_seg <= s_seg;
            p_dp  <= s_dp;
            p_sel <= s_sel;
        end
    end

    // Active digit as a one-hot-high mask; legal only with exactly one low select.
    logic [NUM_DIGITS-1:0] sel_hot;
    logic                  sel_legal;
    logic                  same;

    assign sel_hot   = ~s_sel;
    assign sel_legal = $onehot(sel_hot);
    assign same      = ({s_seg, s_dp, s_sel} == {p_seg, p_dp, p_sel});

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             commit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!sel_legal) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
                TRACK: begin
                    if (!same) begin
                        cnt_d = CNT_W'(1);
                    end else if (cnt_q < CNT_TGT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == CNT_TGT) begin
                            commit  = 1'b1;
                            state_d = HELD;
                        end
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_d = TRACK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    logic [3:0] code;
    logic       code_bad;

    seg_pattern_lut u_lut (
        .pattern (s_seg),
        .code    (code),
        .invalid (code_bad)
    );

    logic [NUM_DIGITS-1:0][3:0] digits_q;
    logic [NUM_DIGITS-1:0]      dp_q, valid_q, mask_q, mask_set;
    logic                       fd_q, err_q;

    assign mask_set = mask_q | sel_hot;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            digits_q <= {NUM_DIGITS{CODE_BLANK}};
            dp_q     <= '0;
            valid_q  <= '0;
            mask_q   <= '0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fd_q <= 1'b0;
            if (commit) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (sel_hot[k]) begin
                        digits_q[k] <= code;
                        dp_q[k]     <= ~s_dp;
                    end
                end
                valid_q <= valid_q | sel_hot;
                if (&mask_set) begin
                    fd_q   <= 1'b1;
                    mask_q <= '0;
                end else begin
                    mask_q <= mask_set;
                end
            end
            // A new invalid commit outranks a same-cycle clear.
            err_q <= (commit & code_bad) | (err_q & ~bus.i_err_clr);
        end
    end

    assign bus.o_digits     = digits_q;
    assign bus.o_dp         = dp_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_frame_done = fd_q;
    assign bus.o_err        = err_q;

`ifdef SEG_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_q <= '0;
        end else if (commit && code_bad) begin
            if (bus.i_err_clr)
                err_cnt_q <= 8'd1;
            else if (err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end else if (bus.i_err_clr) begin
            err_cnt_q <= '0;
        end
    end

    assign bus.o_err_cnt = err_cnt_q;
`else
    // Counter build option off: only the sticky flag reports invalid commits.
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus a randomized run
// against a run-length reference model. Honors SEG_SCAN_ERR_CNT_EN.
module tb_seg_scan_decoder;

    localparam int ND = 6;
    localparam int SC = 4;
    localparam logic [6:0] PATS [0:11] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                           7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // {invalid, code} straight from the display pattern table.
    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h40: return {1'b0, 4'd0};
            7'h79: return {1'b0, 4'd1};
            7'h24: return {1'b0, 4'd2};
            7'h30: return {1'b0, 4'd3};
            7'h19: return {1'b0, 4'd4};
            7'h12: return {1'b0, 4'd5};
            7'h02: return {1'b0, 4'd6};
            7'h78: return {1'b0, 4'd7};
            7'h00: return {1'b0, 4'd8};
            7'h10: return {1'b0, 4'd9};
            7'h3F: return {1'b0, 4'hA};
            7'h7F: return {1'b0, 4'hF};
            default: return {1'b1, 4'hE};
        endcase
    endfunction

    // Reference model: a digit commits one clock after a run of identical,
    // legally-selected samples reaches exactly SC samples.
    logic [ND-1:0][3:0] m_digits;
    logic [ND-1:0]      m_dp, m_valid, m_mask;
    logic               m_fd, m_err;
    int                 m_err_cnt, run, k_idx;
    logic               have_last, pend, legal, bad_c;
    logic [6:0]         last_seg, pend_seg;
    logic               last_dp, pend_dp;
    logic [ND-1:0]      last_sel, pend_sel;
    logic [4:0]         dec;

    always @(posedge clk) begin
        if (rst) begin
            m_digits = '1; m_dp = '0; m_valid = '0; m_mask = '0;
            m_fd = 1'b0; m_err = 1'b0; m_err_cnt = 0;
            run = 0; have_last = 1'b0; pend = 1'b0;
        end else begin
            m_fd  = 1'b0;
            bad_c = 1'b0;
            if (pend) begin
                dec = ref_decode(pend_seg);
                k_idx = 0;
                for (int i = 0; i < ND; i++) if (!pend_sel[i]) k_idx = i;
                m_digits[k_idx] = dec[3:0];
                m_dp[k_idx]     = ~pend_dp;
                m_valid[k_idx]  = 1'b1;
                m_mask[k_idx]   = 1'b1;
                if (m_mask == '1) begin
                    m_fd   = 1'b1;
                    m_mask = '0;
                end
                bad_c = dec[4];
            end
            if (bad_c) begin
                m_err     = 1'b1;
                m_err_cnt = bus.i_err_clr ? 1 : (m_err_cnt < 255 ? m_err_cnt + 1 : 255);
            end else if (bus.i_err_clr) begin
                m_err     = 1'b0;
                m_err_cnt = 0;
            end
            legal = ($countones(~bus.i_dig_sel) == 1);
            if (!legal)
                run = 0;
            else if (have_last && {bus.i_seg, bus.i_dp, bus.i_dig_sel} == {last_seg, last_dp, last_sel})
                run = (run > SC) ? run : run + 1;
            else
                run = 1;
            last_seg = bus.i_seg; last_dp = bus.i_dp; last_sel = bus.i_dig_sel;
            have_last = 1'b1;
            pend     = legal && (run == SC);
            pend_seg = bus.i_seg; pend_dp = bus.i_dp; pend_sel = bus.i_dig_sel;
        end
    end

    task automatic drive(input logic [6:0] seg, input logic dp, input logic [ND-1:0] sel);
        bus.i_seg     = seg;
        bus.i_dp      = dp;
        bus.i_dig_sel = sel;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_err_clr = 1'b0;
        drive(7'h24, 1'b1, 6'b111110);
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.o_digits !== 24'hFFFFFF) begin bad++; $display("FAIL reset_digits: got %h want ffffff", bus.o_digits); end
        total++; if (bus.o_valid !== 6'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_dp !== 6'b0) begin bad++; $display("FAIL reset_dp: got %b want 0", bus.o_dp); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.o_err); end
        total++; if (bus.o_frame_done !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", bus.o_frame_done); end
        // partial dwell, then a reset that must restart the count
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            total++;
            if (bus.o_valid[0] !== (n == 5)) begin
                bad++; $display("FAIL reset_mid_dwell cyc%0d: got %b want %b", n, bus.o_valid[0], (n == 5));
            end
        end
        rst = 1'b1;
        drive(7'h7F, 1'b1, 6'b111111);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single_commit();
        drive(7'h24, 1'b1, 6'b111110);
        repeat (3) @(posedge clk);
        #1 drive(7'h24, 1'b1, 6'b111111);
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.o_valid !== 6'b0) begin bad++; $display("FAIL short_dwell: got %b want 0", bus.o_valid); end
        drive(7'h24, 1'b1, 6'b111110);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) begin
                total++; if (bus.o_valid[0] !== 1'b0) begin bad++; $display("FAIL early_commit: got %b want 0", bus.o_valid[0]); end
            end
        end
        total++; if (bus.o_digits[3:0] !== 4'd2) begin bad++; $display("FAIL single_digit: got %h want 2", bus.o_digits[3:0]); end
        total++; if (bus.o_dp[0] !== 1'b0) begin bad++; $display("FAIL single_dp: got %b want 0", bus.o_dp[0]); end
        total++; if (bus.o_valid !== 6'b000001) begin bad++; $display("FAIL single_valid: got %b want 000001", bus.o_valid); end
    endtask

    task automatic test_frame();
        int fd_cnt = 0;
        int fd_digit = -1;
        logic [ND-1:0] sel;
        for (int d = 0; d < ND; d++) begin
            sel = '1;
            sel[d] = 1'b0;
            drive(PATS[d], (d == 2) ? 1'b0 : 1'b1, sel);
            repeat (6) begin
                @(posedge clk);
                #1;
                if (bus.o_frame_done === 1'b1) begin fd_cnt++; fd_digit = d; end
            end
        end
        total++; if (fd_cnt != 1 || fd_digit != 5) begin bad++; $display("FAIL frame_pulse: got %0d pulses at digit %0d want 1 at 5", fd_cnt, fd_digit); end
        total++; if (bus.o_digits !== 24'h543210) begin bad++; $display("FAIL frame_digits: got %h want 543210", bus.o_digits); end
        total++; if (bus.o_dp !== 6'b000100) begin bad++; $display("FAIL frame_dp: got %b want 000100", bus.o_dp); end
        total++; if (bus.o_valid !== 6'b111111) begin bad++; $display("FAIL frame_valid: got %b want 111111", bus.o_valid); end
    endtask

    task automatic test_glitch();
        int fd_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive((i % 4 < 2) ? 7'h79 : 7'h24, 1'b1, 6'b111110);
            @(posedge clk);
            #1;
            if (bus.o_frame_done === 1'b1) fd_cnt++;
        end
        total++; if (bus.o_digits !== 24'h543210) begin bad++; $display("FAIL glitch_digits: got %h want 543210", bus.o_digits); end
        drive(7'h00, 1'b1, 6'b111100);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.o_frame_done === 1'b1) fd_cnt++;
        end
        total++; if (bus.o_digits !== 24'h543210) begin bad++; $display("FAIL illegal_digits: got %h want 543210", bus.o_digits); end
        total++; if (bus.o_dp !== 6'b000100) begin bad++; $display("FAIL illegal_dp: got %b want 000100", bus.o_dp); end
        total++; if (fd_cnt != 0) begin bad++; $display("FAIL glitch_fd: got %0d pulses want 0", fd_cnt); end
    endtask

    task automatic test_invalid_err();
        drive(7'h55, 1'b1, 6'b111101);
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.o_digits[7:4] !== 4'hE) begin bad++; $display("FAIL invalid_code: got %h want e", bus.o_digits[7:4]); end
        total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL invalid_err: got %b want 1", bus.o_err); end
        drive(7'h56, 1'b1, 6'b111101);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk);
            #1;
            if (n == 4) bus.i_err_clr = 1'b1;
        end
        bus.i_err_clr = 1'b0;
        total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL set_beats_clr: got %b want 1", bus.o_err); end
        bus.i_err_clr = 1'b1;
        @(posedge clk);
        #1 bus.i_err_clr = 1'b0;
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b want 0", bus.o_err); end
`ifdef SEG_SCAN_ERR_CNT_EN
        total++; if (bus.o_err_cnt !== 8'd0) begin bad++; $display("FAIL err_cnt_clear: got %0d want 0", bus.o_err_cnt); end
`endif
    endtask

    task automatic test_dash_blank();
        drive(7'h3F, 1'b1, 6'b110111);
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.o_digits[15:12] !== 4'hA) begin bad++; $display("FAIL dash_code: got %h want a", bus.o_digits[15:12]); end
        drive(7'h7F, 1'b1, 6'b101111);
        repeat (5) @(posedge clk);
        #1;
        total++; if (bus.o_digits[19:16] !== 4'hF) begin bad++; $display("FAIL blank_code: got %h want f", bus.o_digits[19:16]); end
        total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL dash_blank_err: got %b want 0", bus.o_err); end
    endtask

    task automatic test_random();
        int hold = 0;
        logic [ND-1:0] sel;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                hold = $urandom_range(1, 7);
                sel = '1;
                if ($urandom_range(0, 9) < 8) sel[$urandom_range(0, ND - 1)] = 1'b0;
                else sel = ND'($urandom);
                drive(($urandom_range(0, 4) == 0) ? 7'($urandom) : PATS[$urandom_range(0, 11)],
                      1'($urandom), sel);
            end
            hold--;
            bus.i_err_clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            @(posedge clk);
            #1;
            total++; if (bus.o_digits !== m_digits) begin bad++; $display("FAIL rnd_digits c%0d: got %h want %h", c, bus.o_digits, m_digits); end
            total++; if (bus.o_dp !== m_dp) begin bad++; $display("FAIL rnd_dp c%0d: got %b want %b", c, bus.o_dp, m_dp); end
            total++; if (bus.o_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.o_valid, m_valid); end
            total++; if (bus.o_frame_done !== m_fd) begin bad++; $display("FAIL rnd_fd c%0d: got %b want %b", c, bus.o_frame_done, m_fd); end
            total++; if (bus.o_err !== m_err) begin bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, bus.o_err, m_err); end
`ifdef SEG_SCAN_ERR_CNT_EN
            total++; if (bus.o_err_cnt !== 8'(m_err_cnt)) begin bad++; $display("FAIL rnd_err_cnt c%0d: got %0d want %0d", c, bus.o_err_cnt, m_err_cnt); end
`endif
        end
        rst = 1'b0;
        bus.i_err_clr = 1'b0;
    endtask

`ifdef SEG_SCAN_ERR_CNT_EN
    task automatic test_err_cnt_sat();
        bus.i_err_clr = 1'b1;
        @(posedge clk);
        #1 bus.i_err_clr = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 7'h55 : 7'h56, 1'b1, 6'b111110);
            repeat (4) @(posedge clk);
            #1;
        end
        drive(7'h7F, 1'b1, 6'b111111);
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.o_err_cnt !== 8'd255) begin bad++; $display("FAIL err_cnt_sat: got %0d want 255", bus.o_err_cnt); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_commit();
        test_frame();
        test_glitch();
        test_invalid_err();
        test_dash_blank();
        test_random();
`ifdef SEG_SCAN_ERR_CNT_EN
        test_err_cnt_sat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
